// File: rtl/eth_multi_tag_parser_if.sv
// AXI-Stream bus bundle shared by the parser's ingress and egress sides.
interface eth_multi_tag_parser_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_multi_tag_parser.sv
// Stacked-VLAN Ethernet header parser: one-slice passthrough (1-cycle latency, ready = !out_valid || out_ready),
// one registered metadata pulse per frame. Frame counters exist only when ETH_PARSER_STATS_EN is defined.
module eth_multi_tag_parser #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_TAGS   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  eth_multi_tag_parser_if.slave         s_axis,
  eth_multi_tag_parser_if.master        m_axis,
  output logic                          m_meta_valid,
  output logic [15:0]                   m_meta_ethertype,
  output logic [2:0]                    m_meta_tag_count,
  output logic [11:0]                   m_meta_outer_vid,
  output logic [11:0]                   m_meta_inner_vid,
  output logic                          m_meta_is_ipv4,
  output logic                          m_meta_is_ipv6,
  output logic                          m_meta_is_arp,
  output logic                          m_meta_runt_err,
  output logic                          m_meta_tag_overflow,
  input  logic                          stat_clear,
  output logic [31:0]                   stat_frames,
  output logic [31:0]                   stat_vlan_frames,
  output logic [31:0]                   stat_err_frames
);
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {HDR, BODY, ERR_WAIT} state_t;

  state_t                state;
  logic                  out_vld;
  logic                  out_lst;
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  acc;

  logic [8:0]  cnt_q;
  logic [2:0]  tags_q;
  logic [11:0] ovid_q;
  logic [11:0] ivid_q;

  logic [8:0]  pos;
  logic [8:0]  base;
  logic [7:0]  b;
  logic [7:0]  hi;
  logic [15:0] w;
  logic [2:0]  p_tags;
  logic [11:0] p_ovid;
  logic [11:0] p_ivid;
  logic        p_done;
  logic        p_ovf;
  logic [15:0] p_et;

  assign s_axis.tready = !out_vld || m_axis.tready;
  assign m_axis.tvalid = out_vld;
  assign m_axis.tlast  = out_lst;
  assign m_axis.tdata  = out_dat;
  assign acc           = s_axis.tvalid && s_axis.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_lst <= 1'b0;
      out_dat <= '0;
    end else if (s_axis.tready) begin
      out_vld <= s_axis.tvalid;
      if (s_axis.tvalid) begin
        out_dat <= s_axis.tdata;
        out_lst <= s_axis.tlast;
      end
    end
  end

  // Walk the lanes of the current beat; header words sit at 12+4*tags (type) and 14+4*tags (TCI).
  always_comb begin
    p_tags = tags_q;
    p_ovid = ovid_q;
    p_ivid = ivid_q;
    p_done = 1'b0;
    p_ovf  = 1'b0;
    p_et   = 16'h0000;
    hi     = 8'h00;
    w      = 16'h0000;
    pos    = 9'd0;
    base   = 9'd0;
    b      = 8'h00;
    for (int k = 0; k < BYTES; k++) begin
      pos  = cnt_q + 9'(k);
      base = 9'd12 + {4'd0, p_tags, 2'b00};
      b    = s_axis.tdata[8*k +: 8];
      if (!p_done && pos >= base) begin
        case (pos - base)
          9'd0, 9'd2: hi = b;
          9'd1: begin
            w = {hi, b};
            if (w == 16'h8100 || w == 16'h88A8) begin
              if (p_tags == 3'(MAX_TAGS)) begin
                p_done = 1'b1;
                p_ovf  = 1'b1;
                p_et   = w;
              end
            end else begin
              p_done = 1'b1;
              p_et   = w;
            end
          end
          9'd3: begin
            if (p_tags == 3'd0)      p_ovid = {hi[3:0], b};
            else if (p_tags == 3'd1) p_ivid = {hi[3:0], b};
            p_tags = p_tags + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= HDR;
      cnt_q               <= 9'd0;
      tags_q              <= 3'd0;
      ovid_q              <= 12'd0;
      ivid_q              <= 12'd0;
      m_meta_valid        <= 1'b0;
      m_meta_ethertype    <= 16'h0000;
      m_meta_tag_count    <= 3'd0;
      m_meta_outer_vid    <= 12'd0;
      m_meta_inner_vid    <= 12'd0;
      m_meta_is_ipv4      <= 1'b0;
      m_meta_is_ipv6      <= 1'b0;
      m_meta_is_arp       <= 1'b0;
      m_meta_runt_err     <= 1'b0;
      m_meta_tag_overflow <= 1'b0;
    end else begin
      m_meta_valid <= 1'b0;
      case (state)
        HDR: begin
          if (acc) begin
            if (p_done || s_axis.tlast) begin
              // A tlast before resolution reports a runt with whatever tags were complete.
              m_meta_valid        <= 1'b1;
              m_meta_ethertype    <= p_et;
              m_meta_tag_count    <= p_tags;
              m_meta_outer_vid    <= p_ovid;
              m_meta_inner_vid    <= p_ivid;
              m_meta_runt_err     <= !p_done;
              m_meta_tag_overflow <= p_ovf;
              m_meta_is_ipv4      <= p_done && !p_ovf && (p_et == 16'h0800);
              m_meta_is_ipv6      <= p_done && !p_ovf && (p_et == 16'h86DD);
              m_meta_is_arp       <= p_done && !p_ovf && (p_et == 16'h0806);
              cnt_q               <= 9'd0;
              tags_q              <= 3'd0;
              ovid_q              <= 12'd0;
              ivid_q              <= 12'd0;
              if (s_axis.tlast) state <= HDR;
              else if (p_ovf)   state <= ERR_WAIT;
              else              state <= BODY;
            end else begin
              cnt_q  <= cnt_q + 9'(BYTES);
              tags_q <= p_tags;
              ovid_q <= p_ovid;
              ivid_q <= p_ivid;
            end
          end
        end
        BODY, ERR_WAIT: begin
          if (acc && s_axis.tlast) state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

`ifdef ETH_PARSER_STATS_EN
  logic fire;
  logic fire_err;

  assign fire     = acc && (state == HDR) && (p_done || s_axis.tlast);
  assign fire_err = !p_done || p_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames      <= 32'd0;
      stat_vlan_frames <= 32'd0;
      stat_err_frames  <= 32'd0;
    end else if (stat_clear) begin
      stat_frames      <= 32'd0;
      stat_vlan_frames <= 32'd0;
      stat_err_frames  <= 32'd0;
    end else if (fire) begin
      stat_frames <= stat_frames + 32'd1;
      if (fire_err)                  stat_err_frames  <= stat_err_frames + 32'd1;
      else if (p_tags != 3'd0)       stat_vlan_frames <= stat_vlan_frames + 32'd1;
    end
  end
`else
  logic unused_stat_clear;

  assign unused_stat_clear = stat_clear;
  assign stat_frames       = 32'd0;
  assign stat_vlan_frames  = 32'd0;
  assign stat_err_frames   = 32'd0;
`endif
endmodule

// File: tb/tb_eth_multi_tag_parser.sv
// Bench for eth_multi_tag_parser: 64-bit and 128-bit instances against a frame-level header model.
module tb_eth_multi_tag_parser;
  localparam int MAXT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stat_clear = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] et;
    logic [2:0]  tags;
    logic [11:0] ovid;
    logic [11:0] ivid;
    logic        v4;
    logic        v6;
    logic        arp;
    logic        runt;
    logic        ovf;
  } meta_t;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] fb [0:4095];
  int fb_top = 0;
  int fs = 0;
  meta_t e64[$];
  meta_t e128[$];
  logic [128:0] q64[$];
  logic [128:0] q128[$];
  bit chk64 = 1'b1;
  int sf = 0, svf = 0, sef = 0;

  eth_multi_tag_parser_if #(.DATA_WIDTH(64))  sa64();
  eth_multi_tag_parser_if #(.DATA_WIDTH(64))  ma64();
  eth_multi_tag_parser_if #(.DATA_WIDTH(128)) sa128();
  eth_multi_tag_parser_if #(.DATA_WIDTH(128)) ma128();

  logic        mv64, v4_64, v6_64, arp64, runt64, ovf64;
  logic [15:0] et64;
  logic [2:0]  tc64;
  logic [11:0] ov64, iv64;
  logic [31:0] sf64, svf64, sef64;
  logic        mv128, v4_128, v6_128, arp128, runt128, ovf128;
  logic [15:0] et128;
  logic [2:0]  tc128;
  logic [11:0] ov128, iv128;
  logic [31:0] sf128, svf128, sef128;

  eth_multi_tag_parser #(.DATA_WIDTH(64), .MAX_TAGS(MAXT)) dut64 (
    .clk(clk), .rst(rst), .s_axis(sa64), .m_axis(ma64),
    .m_meta_valid(mv64), .m_meta_ethertype(et64), .m_meta_tag_count(tc64),
    .m_meta_outer_vid(ov64), .m_meta_inner_vid(iv64),
    .m_meta_is_ipv4(v4_64), .m_meta_is_ipv6(v6_64), .m_meta_is_arp(arp64),
    .m_meta_runt_err(runt64), .m_meta_tag_overflow(ovf64),
    .stat_clear(stat_clear), .stat_frames(sf64), .stat_vlan_frames(svf64), .stat_err_frames(sef64));

  eth_multi_tag_parser #(.DATA_WIDTH(128), .MAX_TAGS(MAXT)) dut128 (
    .clk(clk), .rst(rst), .s_axis(sa128), .m_axis(ma128),
    .m_meta_valid(mv128), .m_meta_ethertype(et128), .m_meta_tag_count(tc128),
    .m_meta_outer_vid(ov128), .m_meta_inner_vid(iv128),
    .m_meta_is_ipv4(v4_128), .m_meta_is_ipv6(v6_128), .m_meta_is_arp(arp128),
    .m_meta_runt_err(runt128), .m_meta_tag_overflow(ovf128),
    .stat_clear(stat_clear), .stat_frames(sf128), .stat_vlan_frames(svf128), .stat_err_frames(sef128));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT event with no expectation, or wait bound expired", name);
  endtask

  task automatic chk_meta(input string p, input meta_t g, input meta_t e);
    chk({p, ".ethertype"}, 128'(g.et), 128'(e.et));
    chk({p, ".tag_count"}, 128'(g.tags), 128'(e.tags));
    chk({p, ".outer_vid"}, 128'(g.ovid), 128'(e.ovid));
    chk({p, ".inner_vid"}, 128'(g.ivid), 128'(e.ivid));
    chk({p, ".flags"}, 128'({g.v4, g.v6, g.arp, g.runt, g.ovf}),
        128'({e.v4, e.v6, e.arp, e.runt, e.ovf}));
  endtask

  // Walk the frame two bytes at a time from offset 12, as a byte-addressed array.
  function automatic meta_t model(input int s, input int len);
    meta_t m;
    int pos;
    bit done;
    logic [15:0] w;
    logic [11:0] vid;
    m = '0;
    pos = 12;
    done = 1'b0;
    while (!done) begin
      if (pos + 1 >= len) begin
        m.runt = 1'b1;
        done = 1'b1;
      end else begin
        w = {fb[s+pos], fb[s+pos+1]};
        if (w == 16'h8100 || w == 16'h88A8) begin
          if (int'(m.tags) == MAXT) begin
            m.ovf = 1'b1;
            m.et = w;
            done = 1'b1;
          end else if (pos + 3 >= len) begin
            m.runt = 1'b1;
            done = 1'b1;
          end else begin
            vid = {fb[s+pos+2][3:0], fb[s+pos+3]};
            if (m.tags == 3'd0) m.ovid = vid;
            else if (m.tags == 3'd1) m.ivid = vid;
            m.tags = m.tags + 3'd1;
            pos += 4;
          end
        end else begin
          m.et = w;
          done = 1'b1;
        end
      end
    end
    m.v4  = !m.runt && !m.ovf && (m.et == 16'h0800);
    m.v6  = !m.runt && !m.ovf && (m.et == 16'h86DD);
    m.arp = !m.runt && !m.ovf && (m.et == 16'h0806);
    return m;
  endfunction

  task automatic fstart();
    fs = fb_top;
  endtask

  task automatic fbeg();
    fstart();
    for (int i = 0; i < 12; i++) begin
      fb[fb_top] = 8'(i * 17 + 3);
      fb_top++;
    end
  endtask

  task automatic fw(input logic [15:0] w);
    fb[fb_top] = w[15:8];
    fb[fb_top+1] = w[7:0];
    fb_top += 2;
  endtask

  task automatic fpad(input int len);
    while (fb_top - fs < len) begin
      fb[fb_top] = 8'($urandom);
      fb_top++;
    end
  endtask

  task automatic drive_beat(input bit wide, input logic [127:0] d, input bit last);
    int budget;
    bit acc;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    if (wide) begin
      sa128.tdata = d; sa128.tlast = last; sa128.tvalid = 1'b1;
    end else begin
      sa64.tdata = d[63:0]; sa64.tlast = last; sa64.tvalid = 1'b1;
    end
    acc = 1'b0;
    budget = 0;
    while (!acc) begin
      @(negedge clk);
      acc = wide ? sa128.tready : sa64.tready;
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 200) begin
        miss("ingress_accept_timeout");
        acc = 1'b1;
      end
    end
    if (wide) sa128.tvalid = 1'b0;
    else      sa64.tvalid = 1'b0;
  endtask

  task automatic send(input bit wide, input int s, input int len);
    meta_t m;
    int nb;
    logic [127:0] d;
    bit last;
    m = model(s, len);
    nb = wide ? 16 : 8;
    if (wide) e128.push_back(m);
    else begin
      e64.push_back(m);
      sf++;
      if (m.runt || m.ovf) sef++;
      else if (m.tags != 3'd0) svf++;
    end
    for (int o = 0; o < len; o += nb) begin
      d = '0;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = fb[s+o+k];
      last = (o + nb >= len);
      if (wide) q128.push_back({last, d});
      else      q64.push_back({last, d});
      drive_beat(wide, d, last);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q64.size() != 0 || e64.size() != 0 || q128.size() != 0 || e128.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) miss("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ma64.tready  = ($urandom_range(0, 3) != 0);
      ma128.tready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    logic [128:0] eb;
    meta_t g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ma64.tvalid && ma64.tready && chk64) begin
          if (q64.size() == 0) miss("egress64_extra_beat");
          else begin
            eb = q64.pop_front();
            chk("egress64.tdata", 128'(ma64.tdata), 128'(eb[63:0]));
            chk("egress64.tlast", 128'(ma64.tlast), 128'(eb[128]));
          end
        end
        if (mv64) begin
          g = {et64, tc64, ov64, iv64, v4_64, v6_64, arp64, runt64, ovf64};
          if (e64.size() == 0) miss("meta64_extra_pulse");
          else chk_meta("meta64", g, e64.pop_front());
        end
      end
    end
  end

  initial begin
    logic [128:0] eb;
    meta_t g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ma128.tvalid && ma128.tready) begin
          if (q128.size() == 0) miss("egress128_extra_beat");
          else begin
            eb = q128.pop_front();
            chk("egress128.tdata", ma128.tdata, eb[127:0]);
            chk("egress128.tlast", 128'(ma128.tlast), 128'(eb[128]));
          end
        end
        if (mv128) begin
          g = {et128, tc128, ov128, iv128, v4_128, v6_128, arp128, runt128, ovf128};
          if (e128.size() == 0) miss("meta128_extra_pulse");
          else chk_meta("meta128", g, e128.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    meta_t m;
    logic [127:0] d;
    int f_ip4, f_qinq, f_ovf, f_runt, f_arp, f_vlan, f_part;
    int f_w [4];
    int l_w [4];
    logic [15:0] vids [4];

    sa64.tvalid = 1'b0; sa64.tdata = '0; sa64.tlast = 1'b0;
    sa128.tvalid = 1'b0; sa128.tdata = '0; sa128.tlast = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.m_tvalid", 128'(ma64.tvalid), 128'(0));
    chk("reset.m_tdata", 128'(ma64.tdata), 128'(0));
    chk("reset.m_tlast", 128'(ma64.tlast), 128'(0));
    chk("reset.meta_valid", 128'(mv64), 128'(0));
    chk("reset.meta_fields", 128'({et64, tc64, ov64, iv64, v4_64, v6_64, arp64, runt64, ovf64}), 128'(0));
    chk("reset.stats", 128'({sf64, svf64, sef64}), 128'(0));
    rst = 1'b0;

    fbeg(); fw(16'h0800); fpad(24); f_ip4 = fs;
    fbeg(); fw(16'h88A8); fw(16'hE00A); fw(16'h8100); fw(16'h2005); fw(16'h86DD); fpad(32); f_qinq = fs;
    fbeg(); fw(16'h8100); fw(16'h0001); fw(16'h8100); fw(16'h0002); fw(16'h8100); fw(16'h0003);
    fw(16'h0800); fpad(40); f_ovf = fs;
    fstart(); fpad(8); f_runt = fs;
    fbeg(); fw(16'h0806); fpad(16); f_arp = fs;
    fbeg(); fw(16'h8100); fw(16'h0064); fw(16'h0800); fpad(32); f_vlan = fs;
    fbeg(); fw(16'h8100); fw(16'h0077); fw(16'h86DD); fpad(32); f_part = fs;

    m = model(f_ip4, 24);
    chk("model.ipv4.et", 128'(m.et), 128'(16'h0800));
    chk("model.ipv4.flags", 128'({m.tags, m.v4, m.ovid, m.ivid}), 128'({3'd0, 1'b1, 12'd0, 12'd0}));
    m = model(f_qinq, 32);
    chk("model.qinq.vids", 128'({m.tags, m.ovid, m.ivid, m.v6}), 128'({3'd2, 12'd10, 12'd5, 1'b1}));
    m = model(f_ovf, 40);
    chk("model.ovf", 128'({m.ovf, m.et, m.tags, m.v4}), 128'({1'b1, 16'h8100, 3'd2, 1'b0}));
    m = model(f_runt, 8);
    chk("model.runt", 128'({m.runt, m.et, m.tags}), 128'({1'b1, 16'h0000, 3'd0}));

    send(1'b0, f_ip4, 24);
    send(1'b0, f_qinq, 32);
    send(1'b0, f_ovf, 40);
    send(1'b0, f_runt, 8);
    send(1'b0, f_arp, 16);
    send(1'b0, f_vlan, 32);
    drain();

    // Reset in the middle of a frame: only the first beat goes in.
    chk64 = 1'b0;
    d = '0;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = fb[f_part+k];
    drive_beat(1'b0, d, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk64 = 1'b1;
    send(1'b0, f_vlan, 32);
    drain();

    vids[0] = 16'h0123; vids[1] = 16'hAFFF; vids[2] = 16'h0001; vids[3] = 16'h6800;
    for (int i = 0; i < 4; i++) begin
      fbeg(); fw(16'h8100); fw(vids[i]); fw(16'h0806);
      l_w[i] = (i % 2 == 0) ? 32 : 48;
      fpad(l_w[i]);
      f_w[i] = fs;
    end
    m = model(f_w[1], l_w[1]);
    chk("model.vlan_arp", 128'({m.arp, m.tags, m.ovid}), 128'({1'b1, 3'd1, 12'hFFF}));
    for (int i = 0; i < 4; i++) send(1'b1, f_w[i], l_w[i]);
    drain();

    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    sf = 0; svf = 0; sef = 0;
    chk("stats.after_clear", 128'({sf64, svf64, sef64}), 128'(0));
    send(1'b0, f_vlan, 32);
    send(1'b0, f_runt, 8);
    send(1'b0, f_vlan, 32);
    send(1'b0, f_vlan, 32);
    drain();
    chk("model.stat_counts", 128'({sf, svf, sef}), 128'({32'd4, 32'd3, 32'd1}));
`ifdef ETH_PARSER_STATS_EN
    chk("stat_frames", 128'(sf64), 128'(sf));
    chk("stat_vlan_frames", 128'(svf64), 128'(svf));
    chk("stat_err_frames", 128'(sef64), 128'(sef));
`else
    chk("stat_frames.off", 128'(sf64), 128'(0));
    chk("stat_vlan_frames.off", 128'(svf64), 128'(0));
    chk("stat_err_frames.off", 128'(sef64), 128'(0));
`endif
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    chk("stats.cleared", 128'({sf64, svf64, sef64}), 128'(0));

    chk("pending.total", 128'(q64.size() + e64.size() + q128.size() + e128.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
